// File: rtl/ad7264_frame_sequencer.sv
// SPI frame sequencer for the dual-channel AD7264 (CPOL=1, CPHA=1): SS/SCLK generation,
// MSB-first command shift-out and simultaneous capture of both MISO lines into parallel results.
module ad7264_frame_sequencer #(
    parameter int CLK_DIV     = 2,
    parameter int FRAME_BITS  = 32,
    parameter int CMD_BITS    = 8,
    parameter int DATA_BITS   = 14,
    parameter int DATA_OFFSET = 16,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int QUIET       = 4
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CMD_BITS-1:0]  cmd,
    output logic                 busy,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISOA,
    input  logic                 MISOB,
    output logic                 SS,
    output logic [DATA_BITS-1:0] data_a,
    output logic [DATA_BITS-1:0] data_b,
    output logic                 valid
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > QUIET) ? CS_HOLD : QUIET;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_QUIET
    } state_t;

    state_t                r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt;
    logic [CMD_BITS-1:0]   r_cmd, w_cmd;
    logic [FRAME_BITS-1:0] r_rx_a, w_rx_a;
    logic [FRAME_BITS-1:0] r_rx_b, w_rx_b;
    logic                  r_sclk, w_sclk;
    logic                  r_mosi, w_mosi;
    logic                  r_ss, w_ss;
    logic                  r_busy, w_busy;
    logic                  r_valid, w_valid;
    logic [DATA_BITS-1:0]  r_data_a, w_data_a;
    logic [DATA_BITS-1:0]  r_data_b, w_data_b;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_cmd     <= '0;
            r_rx_a    <= '0;
            r_rx_b    <= '0;
            r_sclk    <= 1'b1;
            r_mosi    <= 1'b0;
            r_ss      <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data_a  <= '0;
            r_data_b  <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bit_cnt <= w_bit_cnt;
            r_cmd     <= w_cmd;
            r_rx_a    <= w_rx_a;
            r_rx_b    <= w_rx_b;
            r_sclk    <= w_sclk;
            r_mosi    <= w_mosi;
            r_ss      <= w_ss;
            r_busy    <= w_busy;
            r_valid   <= w_valid;
            r_data_a  <= w_data_a;
            r_data_b  <= w_data_b;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bit_cnt = r_bit_cnt;
        w_cmd     = r_cmd;
        w_rx_a    = r_rx_a;
        w_rx_b    = r_rx_b;
        w_sclk    = r_sclk;
        w_mosi    = r_mosi;
        w_ss      = r_ss;
        w_busy    = r_busy;
        w_valid   = 1'b0;
        w_data_a  = r_data_a;
        w_data_b  = r_data_b;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cmd     = cmd;
                    w_state   = S_SETUP;
                    w_ss      = 1'b0;
                    w_busy    = 1'b1;
                    w_sclk    = 1'b1;
                    w_mosi    = 1'b0;
                    w_cnt     = '0;
                    w_bit_cnt = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                    w_cnt  = '0;
                    w_sclk = ~r_sclk;
                    if (r_sclk) begin
                        // Falling edge: present next command bit; zeros fill once the command is exhausted.
                        w_mosi = r_cmd[CMD_BITS-1];
                        w_cmd  = r_cmd << 1;
                    end else begin
                        w_rx_a    = {r_rx_a[FRAME_BITS-2:0], MISOA};
                        w_rx_b    = {r_rx_b[FRAME_BITS-2:0], MISOB};
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            w_state = S_HOLD;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                    w_ss     = 1'b1;
                    w_mosi   = 1'b0;
                    w_data_a = r_rx_a[DATA_OFFSET +: DATA_BITS];
                    w_data_b = r_rx_b[DATA_OFFSET +: DATA_BITS];
                    w_valid  = 1'b1;
                    w_state  = S_QUIET;
                    w_cnt    = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_QUIET: begin
                if (r_cnt == CNT_W'(QUIET - 1)) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign busy   = r_busy;
    assign SCLK   = r_sclk;
    assign MOSI   = r_mosi;
    assign SS     = r_ss;
    assign data_a = r_data_a;
    assign data_b = r_data_b;
    assign valid  = r_valid;

endmodule

// File: tb/tb_ad7264_frame_sequencer.sv
// Directed/randomized bench for ad7264_frame_sequencer: an ADC model drives MISO on falling SCLK and
// each frame's timing, MOSI pattern and results are predicted from frame-level rules.
module tb_ad7264_frame_sequencer;

    logic        Clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cmd;
    logic        busy, SCLK, MOSI, SS, valid;
    logic        MISOA = 1'b0;
    logic        MISOB = 1'b0;
    logic [13:0] data_a, data_b;

    logic [31:0] tx_a = '0;
    logic [31:0] tx_b = '0;
    int          idx = 31;
    int          tests = 0;
    int          fails = 0;

    ad7264_frame_sequencer dut (
        .Clk(Clk), .reset(reset), .start(start), .cmd(cmd), .busy(busy),
        .SCLK(SCLK), .MOSI(MOSI), .MISOA(MISOA), .MISOB(MISOB), .SS(SS),
        .data_a(data_a), .data_b(data_b), .valid(valid)
    );

    always #5 Clk = ~Clk;

    // ADC model: shifts the frame word out MSB-first on each falling SCLK while selected
    always @(negedge SCLK or posedge SS) begin
        if (SS) begin
            idx = 31;
        end else if (idx >= 0) begin
            MISOA = tx_a[idx];
            MISOB = tx_b[idx];
            idx   = idx - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"}, SS, 1'b1);
        check({tag, "_sclk"}, SCLK, 1'b1);
        check({tag, "_mosi"}, MOSI, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_data"}, {data_a, data_b}, 28'h0);
    endtask

    // One frame from start request to busy drop; abort_rise>0 resets right after that SCLK rise.
    task automatic run_frame(input logic [7:0] c, input logic [31:0] wa, input logic [31:0] wb,
                             input int abort_rise, input bit pulse_mid);
        int          rises, falls, ss_low, vcnt, vt, done_t, vlate;
        logic        prev_sclk, ss_seen_high, sclk_at_ss_rise;
        logic [31:0] mosi_seen, mosi_exp;
        logic [13:0] da, db;
        rises = 0; falls = 0; ss_low = 0; vcnt = 0; vt = -1; done_t = -1;
        prev_sclk = 1'b1; ss_seen_high = 1'b0; sclk_at_ss_rise = 1'bx;
        mosi_seen = '0; da = '0; db = '0;
        tx_a = wa; tx_b = wb;
        @(negedge Clk);
        cmd = c; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_ss", SS, 1'b0);
        for (int t = 0; t < 400; t++) begin
            if (t > 0) @(negedge Clk);
            if (pulse_mid && t == 50) begin start = 1'b1; cmd = ~c; end
            if (pulse_mid && t == 51) start = 1'b0;
            if (!SS) ss_low++;
            if (SS && !ss_seen_high) begin ss_seen_high = 1'b1; sclk_at_ss_rise = SCLK; end
            if (prev_sclk && !SCLK) falls++;
            if (!prev_sclk && SCLK) begin
                rises++;
                if (rises <= 32) mosi_seen[32-rises] = MOSI;
                if (abort_rise > 0 && rises == abort_rise) begin
                    #1 reset = 1'b1;
                    #1 check_reset_outputs("abort");
                    @(negedge Clk);
                    reset = 1'b0;
                    vlate = 0;
                    for (int i = 0; i < 160; i++) begin
                        @(negedge Clk);
                        if (valid) vlate++;
                    end
                    check("abort_no_valid", vlate, 0);
                    check("abort_idle_ss", SS, 1'b1);
                    return;
                end
            end
            if (valid) begin vcnt++; vt = t; da = data_a; db = data_b; end
            prev_sclk = SCLK;
            if (!busy) begin done_t = t; break; end
        end
        for (int n = 0; n < 32; n++) mosi_exp[31-n] = (n < 8) ? c[7-n] : 1'b0;
        check("valid_count", vcnt, 1);
        check("valid_time", vt, 132);
        check("data_a", da, wa[29:16]);
        check("data_b", db, wb[29:16]);
        check("sclk_rises", rises, 32);
        check("sclk_falls", falls, 32);
        check("ss_low_cycles", ss_low, 132);
        check("sclk_at_ss_rise", sclk_at_ss_rise, 1'b1);
        check("mosi_bits", mosi_seen, mosi_exp);
        check("busy_drop", done_t, 136);
        check("data_a_held", data_a, wa[29:16]);
        if (pulse_mid) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge Clk);
                check("no_queued_frame", {SS, busy}, 2'b10);
            end
        end
    endtask

    initial begin
        int          n, w;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; cmd = '0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge Clk);
        reset = 1'b0;

        run_frame(8'hA5, {2'b00, 14'h2ABC, 16'h0}, {2'b00, 14'h1234, 16'h0}, 0, 1'b0);

        @(negedge Clk);
        check("idle_data_nonzero", data_a, 14'h2ABC);
        #1 reset = 1'b1;
        #1 check_reset_outputs("idle_rst");
        @(negedge Clk);
        reset = 1'b0;

        repeat (4) run_frame(8'($urandom), $urandom, $urandom, 0, 1'b0);

        run_frame(8'($urandom), $urandom, $urandom, 0, 1'b1);

        // start held high: back-to-back frames separated by QUIET+1 SS-high cycles
        ra = $urandom; rb = $urandom;
        tx_a = ra; tx_b = rb;
        @(negedge Clk);
        cmd = 8'h3C; start = 1'b1;
        for (int i = 0; i < 10 && SS; i++) @(negedge Clk);
        check("b2b_first_ss", SS, 1'b0);
        for (int i = 0; i < 200 && !SS; i++) @(negedge Clk);
        check("b2b_first_end", SS, 1'b1);
        n = 0;
        for (int i = 0; i < 20 && SS; i++) begin n++; @(negedge Clk); end
        check("b2b_gap", n, 5);
        start = 1'b0;
        w = 0;
        for (int i = 0; i < 200 && !valid; i++) begin w++; @(negedge Clk); end
        check("b2b_second_valid", valid, 1'b1);
        check("b2b_second_data", {data_a, data_b}, {ra[29:16], rb[29:16]});
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        check("b2b_idle", busy, 1'b0);

        run_frame(8'($urandom), $urandom, $urandom, 10, 1'b0);
        run_frame(8'($urandom), $urandom, $urandom, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
